// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, queue entry type and constants for the
//               write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // r0 is hardwired zero and is never written or forwarded
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order pending-write FIFO. Besides the head it exposes
//               every slot in age order (index 0 = oldest) with a valid bit,
//               so the bypass logic can pick the youngest match by index.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output wb_entry_t              head,
  output logic      [DEPTH-1:0]  valid,
  output wb_entry_t [DEPTH-1:0]  entries
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  // One bit wider than the pointers so full and empty are distinguishable
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Age-ordered view: slot i is the i-th oldest pending entry
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [PTR_W-1:0] slot;
    assign slot       = rd_ptr + PTR_W'(i);
    assign valid[i]   = (count > (PTR_W+1)'(i));
    assign entries[i] = mem[slot];
  end

endmodule : wb_queue
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage. Selects ALU/load result at accept time,
//               drops writes to r0, queues pending writes in order, drives
//               the register-file write port and provides associative
//               bypass lookups for two ID source operands.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic              writeRegIn,
  input  logic              memToReg,
  input  logic [ADDR_W-1:0] rdIn,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] memData,
  input  logic              portBusy,
  output logic              writeReg,
  output logic [ADDR_W-1:0] rdOut,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] rsA,
  input  logic [ADDR_W-1:0] rsB,
  output logic              hitA,
  output logic              hitB,
  output logic [DATA_W-1:0] fwdA,
  output logic [DATA_W-1:0] fwdB,
  output logic [7:0]        retired
);

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic      [DEPTH-1:0] valid;
  wb_entry_t [DEPTH-1:0] entries;

  // Ready only looks at fullness, never at a same-cycle drain
  assign inReady = !full;

  // Transactions without a real destination are consumed and dropped
  assign push            = inValid && inReady && writeRegIn && (rdIn != ZERO_REG);
  assign push_entry.rd   = rdIn;
  assign push_entry.data = memToReg ? memData : aluResult;

  assign writeReg  = !empty && !portBusy;
  assign pop       = writeReg;
  assign rdOut     = empty ? '0 : head.rd;
  assign writeData = empty ? '0 : head.data;

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .valid      (valid),
    .entries    (entries)
  );

  // Bypass search: scanning oldest to youngest lets the youngest match win
  always_comb begin
    hitA = 1'b0;
    hitB = 1'b0;
    fwdA = '0;
    fwdB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (rsA != ZERO_REG) && (entries[i].rd == rsA)) begin
        hitA = 1'b1;
        fwdA = entries[i].data;
      end
      if (valid[i] && (rsB != ZERO_REG) && (entries[i].rd == rsB)) begin
        hitB = 1'b1;
        fwdB = entries[i].data;
      end
    end
  end

  // Count of register writes performed, free-running with wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (writeReg) begin
      retired <= retired + 8'd1;
    end
  end

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic       clock;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic       writeRegIn;
  logic       memToReg;
  logic [2:0] rdIn;
  logic [7:0] aluResult;
  logic [7:0] memData;
  logic       portBusy;
  logic       writeReg;
  logic [2:0] rdOut;
  logic [7:0] writeData;
  logic [2:0] rsA;
  logic [2:0] rsB;
  logic       hitA;
  logic       hitB;
  logic [7:0] fwdA;
  logic [7:0] fwdB;
  logic [7:0] retired;

  int num_checks = 0;
  int num_fail   = 0;

  wb_stage #(
    .DEPTH (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .writeRegIn (writeRegIn),
    .memToReg   (memToReg),
    .rdIn       (rdIn),
    .aluResult  (aluResult),
    .memData    (memData),
    .portBusy   (portBusy),
    .writeReg   (writeReg),
    .rdOut      (rdOut),
    .writeData  (writeData),
    .rsA        (rsA),
    .rsB        (rsB),
    .hitA       (hitA),
    .hitB       (hitB),
    .fwdA       (fwdA),
    .fwdB       (fwdB),
    .retired    (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] rd, input logic mtr,
                       input logic [7:0] alu, input logic [7:0] mem);
    inValid    = 1'b1;
    writeRegIn = 1'b1;
    rdIn       = rd;
    memToReg   = mtr;
    aluResult  = alu;
    memData    = mem;
  endtask

  initial begin
    reset = 1'b0; inValid = 1'b0; writeRegIn = 1'b0; memToReg = 1'b0;
    rdIn = '0; aluResult = '0; memData = '0; portBusy = 1'b0;
    rsA = 3'd3; rsB = 3'd2;
    tick(); tick();

    // Outputs while held in reset
    check("rst_inReady",   32'(inReady),   1);
    check("rst_writeReg",  32'(writeReg),  0);
    check("rst_rdOut",     32'(rdOut),     0);
    check("rst_writeData", 32'(writeData), 0);
    check("rst_hitA",      32'(hitA),      0);
    check("rst_fwdB",      32'(fwdB),      0);
    check("rst_retired",   32'(retired),   0);
    reset = 1'b1;
    tick();

    // Single ALU write to r3
    drive(3'd3, 1'b0, 8'h5A, 8'hFF);
    tick();
    inValid = 1'b0;
    #1;
    check("single_writeReg",  32'(writeReg),  1);
    check("single_rdOut",     32'(rdOut),     3);
    check("single_writeData", 32'(writeData), 8'h5A);
    check("single_hitA",      32'(hitA),      1);
    check("single_fwdA",      32'(fwdA),      8'h5A);
    check("single_retired0",  32'(retired),   0);
    tick();
    check("single_retired1",  32'(retired),   1);
    check("single_drained",   32'(writeReg),  0);

    // Load data select
    drive(3'd2, 1'b1, 8'h77, 8'hC3);
    tick();
    inValid = 1'b0;
    #1;
    check("load_rdOut",     32'(rdOut),     2);
    check("load_writeData", 32'(writeData), 8'hC3);
    check("load_hitB",      32'(hitB),      1);
    check("load_fwdB",      32'(fwdB),      8'hC3);
    tick();
    check("load_retired", 32'(retired), 2);

    // Write to r0 is consumed but dropped
    drive(3'd0, 1'b0, 8'h99, 8'h00);
    tick();
    inValid = 1'b0;
    #1;
    check("r0_writeReg", 32'(writeReg), 0);
    tick();
    check("r0_retired", 32'(retired), 2);

    // Non-writing instruction is dropped too
    drive(3'd4, 1'b0, 8'h44, 8'h00);
    writeRegIn = 1'b0;
    tick();
    inValid = 1'b0;
    #1;
    check("nowr_writeReg", 32'(writeReg), 0);

    // Back-pressure: port busy, three back-to-back offers
    portBusy = 1'b1;
    drive(3'd1, 1'b0, 8'hA1, 8'h00);
    #1;
    check("bp_ready0", 32'(inReady), 1);
    tick();
    drive(3'd6, 1'b0, 8'hB6, 8'h00);
    #1;
    check("bp_ready1", 32'(inReady), 1);
    tick();
    drive(3'd7, 1'b0, 8'hC7, 8'h00);
    #1;
    check("bp_ready2_full", 32'(inReady), 0);
    tick();
    inValid = 1'b0;
    #1;
    check("bp_busy_writeReg", 32'(writeReg),  0);
    check("bp_head_rdOut",    32'(rdOut),     1);
    check("bp_head_data",     32'(writeData), 8'hA1);
    rsA = 3'd7;
    #1;
    check("bp_third_not_taken", 32'(hitA), 0);
    portBusy = 1'b0;
    #1;
    check("bp_drain1_writeReg", 32'(writeReg),  1);
    check("bp_drain1_rdOut",    32'(rdOut),     1);
    check("bp_drain1_data",     32'(writeData), 8'hA1);
    check("bp_drain1_ready",    32'(inReady),   0);
    tick();
    check("bp_drain2_writeReg", 32'(writeReg),  1);
    check("bp_drain2_rdOut",    32'(rdOut),     6);
    check("bp_drain2_data",     32'(writeData), 8'hB6);
    check("bp_drain2_ready",    32'(inReady),   1);
    tick();
    check("bp_done_writeReg", 32'(writeReg), 0);
    check("bp_done_retired",  32'(retired),  4);
    check("bp_done_ready",    32'(inReady),  1);

    // Bypass priority with duplicate destination
    portBusy = 1'b1;
    drive(3'd5, 1'b0, 8'h11, 8'h00);
    tick();
    drive(3'd5, 1'b0, 8'h22, 8'h00);
    tick();
    inValid = 1'b0;
    rsA = 3'd5; rsB = 3'd4;
    #1;
    check("byp_hitA", 32'(hitA), 1);
    check("byp_fwdA", 32'(fwdA), 8'h22);
    check("byp_hitB", 32'(hitB), 0);
    check("byp_fwdB", 32'(fwdB), 0);
    rsA = 3'd0;
    #1;
    check("byp_r0_hitA", 32'(hitA), 0);
    check("byp_r0_fwdA", 32'(fwdA), 0);
    rsA = 3'd5;
    portBusy = 1'b0;
    #1;
    check("byp_drain1_data", 32'(writeData), 8'h11);
    tick();
    check("byp_drain2_data", 32'(writeData), 8'h22);
    check("byp_after_pop_fwdA", 32'(fwdA), 8'h22);
    tick();
    check("byp_done_hitA",   32'(hitA),    0);
    check("byp_done_retired", 32'(retired), 6);

    // Reset asserted with two writes pending
    portBusy = 1'b1;
    drive(3'd3, 1'b0, 8'h33, 8'h00);
    tick();
    drive(3'd4, 1'b0, 8'h44, 8'h00);
    tick();
    inValid = 1'b0;
    rsA = 3'd3;
    #1;
    check("mid_pending_hitA", 32'(hitA), 1);
    reset = 1'b0;
    #1;
    portBusy = 1'b0;
    #1;
    check("mid_rst_writeReg", 32'(writeReg), 0);
    check("mid_rst_inReady",  32'(inReady),  1);
    check("mid_rst_retired",  32'(retired),  0);
    check("mid_rst_hitA",     32'(hitA),     0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rel_writeReg", 32'(writeReg), 0);
    check("mid_rel_inReady",  32'(inReady),  1);
    check("mid_rel_retired",  32'(retired),  0);
    check("mid_rel_hitA",     32'(hitA),     0);

    // Counter wrap: 256 streamed writes, one accepted and one drained per cycle
    for (int k = 0; k < 256; k++) begin
      drive(3'((k % 7) + 1), 1'b0, 8'(k), 8'h00);
      tick();
      check("wrap_stream_data", 32'(writeData), k);
    end
    inValid = 1'b0;
    #1;
    check("wrap_last_writeReg", 32'(writeReg), 1);
    check("wrap_pre_retired",   32'(retired),  255);
    tick();
    check("wrap_retired_zero", 32'(retired),  0);
    check("wrap_idle",         32'(writeReg), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire
